vec_mem_sequencer: RTL and testbench

// Parametrised MEM-stage sequencer that serialises one vector load or store into per-element

---
 rtl/vec_mem_pkg.sv | 17 +
 rtl/vec_mem_addr_gen.sv | 59 +++++
 rtl/vec_mem_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_vec_mem_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_pkg.sv
// Shared definitions for the vector memory sequencer: FSM state encoding
// and the lane-index width helper.
package vec_mem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Lane index width, never narrower than one bit (LANES=1 still needs a counter).
  function automatic int unsigned lane_idx_w(input int unsigned lanes);
    return (lanes <= 1) ? 1 : $clog2(lanes);
  endfunction

endpackage

// File: rtl/vec_mem_addr_gen.sv
// Strided address accumulator: loads base/stride on start, then adds the
// stride once per issued lane. Also tracks the lane index and flags the last lane.
module vec_mem_addr_gen
  import vec_mem_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int ADDR_W = 19,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              last_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // Next address/index: reload on start, accumulate (wrapping) on each step.
  always_comb begin
    addr_d   = addr_q;
    stride_d = stride_q;
    idx_d    = idx_q;
    if (start_i) begin
      addr_d   = base_i;
      stride_d = stride_i;
      idx_d    = '0;
    end else if (step_i) begin
      addr_d = addr_q + stride_q;
      idx_d  = idx_q + 1'b1;
    end
  end

  // Accumulator state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      stride_q <= '0;
      idx_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      stride_q <= stride_d;
      idx_q    <= idx_d;
    end
  end

  assign addr_o = addr_q;
  assign idx_o  = idx_q;
  assign last_o = (idx_q == LAST_IDX);

endmodule

// File: rtl/vec_mem_sequencer.sv
// MEM-stage sequencer: serialises one vector load/store into per-element
// accesses on a single-port scalar RAM, gathers load data back into a vector,
// and stalls the pipeline while busy.
//
// Request handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE; requests seen in any
// other state are dropped, so the requester must hold req_valid until it sees
// the transfer. All request fields are captured on that edge only.
module vec_mem_sequencer
  import vec_mem_pkg::*;
#(
  parameter int LANES   = 16,
  parameter int ELEM_W  = 16,
  parameter int ADDR_W  = 19,
  parameter int RD_W    = 5,
  parameter int MEM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_base,
  input  logic [ADDR_W-1:0]       req_stride,
  input  logic [RD_W-1:0]         req_rd,
  input  logic [LANES*ELEM_W-1:0] req_wdata,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [ELEM_W-1:0]       mem_wdata,
  output logic                    mem_wren,
  input  logic [ELEM_W-1:0]       mem_rdata,
  output logic                    rsp_valid,
  output logic [RD_W-1:0]         rsp_rd,
  output logic [LANES*ELEM_W-1:0] rsp_rdata,
  output logic                    done,
  output logic                    stall,
  output state_t                  state_dbg
);

  localparam int IDX_W = lane_idx_w(LANES);
  localparam int VEC_W = LANES * ELEM_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  state_t state_q, state_d;
  logic              wr_q, wr_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [VEC_W-1:0]  wvec_q, wvec_d;
  logic              mem_wren_q, mem_wren_d;
  logic [ELEM_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              vld_pipe_q [MEM_LAT];
  logic [IDX_W-1:0]  idx_pipe_q [MEM_LAT];
  logic [ELEM_W-1:0] lane_buf_q [LANES];
  logic              rsp_valid_q, done_q;
  logic [RD_W-1:0]   rsp_rd_q;
  logic [VEC_W-1:0]  rsp_rdata_q;
  logic [VEC_W-1:0]  gathered;

  logic              accept, issuing, cap_vld, cap_last;
  logic [IDX_W-1:0]  cap_idx;
  logic [ADDR_W-1:0] ag_addr;
  logic [IDX_W-1:0]  ag_idx;
  logic              ag_last;

  assign accept   = req_valid && (state_q == ST_IDLE);
  assign issuing  = (state_q == ST_ISSUE);
  assign cap_vld  = vld_pipe_q[MEM_LAT-1];
  assign cap_idx  = idx_pipe_q[MEM_LAT-1];
  assign cap_last = cap_vld && (cap_idx == LAST_IDX);

  vec_mem_addr_gen #(
    .LANES  (LANES),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .start_i  (accept),
    .base_i   (req_base),
    .stride_i (req_stride),
    .step_i   (issuing && !ag_last),
    .addr_o   (ag_addr),
    .idx_o    (ag_idx),
    .last_o   (ag_last)
  );

  // Sequencing FSM: issue every lane, wait for the read pipe to empty on loads.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: if (ag_last) state_d = wr_q ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (cap_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request capture and store-lane serialisation (store vector shifts down one lane per issue).
  always_comb begin
    wr_d        = wr_q;
    rd_d        = rd_q;
    wvec_d      = wvec_q;
    mem_wren_d  = mem_wren_q;
    mem_wdata_d = mem_wdata_q;
    if (accept) begin
      wr_d        = req_write;
      rd_d        = req_rd;
      wvec_d      = req_wdata >> ELEM_W;
      mem_wren_d  = req_write;
      mem_wdata_d = req_write ? req_wdata[ELEM_W-1:0] : '0;
    end else if (issuing) begin
      if (ag_last) begin
        mem_wren_d  = 1'b0;
        mem_wdata_d = '0;
      end else begin
        mem_wdata_d = wr_q ? wvec_q[ELEM_W-1:0] : '0;
        wvec_d      = wvec_q >> ELEM_W;
      end
    end
  end

  // Full response vector including the lane arriving this cycle.
  always_comb begin
    gathered = '0;
    for (int i = 0; i < LANES; i++) begin
      gathered[i*ELEM_W +: ELEM_W] =
        (cap_vld && (cap_idx == IDX_W'(i))) ? mem_rdata : lane_buf_q[i];
    end
  end

  // Control and request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      rd_q        <= '0;
      wvec_q      <= '0;
      mem_wren_q  <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      wvec_q      <= wvec_d;
      mem_wren_q  <= mem_wren_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Read-latency pipe: tags each load address cycle with its lane index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < MEM_LAT; j++) begin
        vld_pipe_q[j] <= 1'b0;
        idx_pipe_q[j] <= '0;
      end
    end else begin
      vld_pipe_q[0] <= issuing && !wr_q;
      idx_pipe_q[0] <= ag_idx;
      for (int j = 1; j < MEM_LAT; j++) begin
        vld_pipe_q[j] <= vld_pipe_q[j-1];
        idx_pipe_q[j] <= idx_pipe_q[j-1];
      end
    end
  end

  // Lane buffer: returning read data lands in the slot its tag names.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) lane_buf_q[i] <= '0;
    end else if (cap_vld) begin
      lane_buf_q[cap_idx] <= mem_rdata;
    end
  end

  // Completion pulses and held load response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      done_q      <= 1'b0;
      rsp_rd_q    <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= cap_last;
      done_q      <= (state_d == ST_DONE);
      if (cap_last) begin
        rsp_rd_q    <= rd_q;
        rsp_rdata_q <= gathered;
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign stall     = ~req_ready;
  assign mem_addr  = ag_addr;
  assign mem_wdata = mem_wdata_q;
  assign mem_wren  = mem_wren_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_rdata = rsp_rdata_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Bench for vec_mem_sequencer: two instances (read latency 1 and 3) share one
// request stream; a per-instance monitor predicts every cycle from the
// transaction (address = base + i*stride, response timing, lane data).
module tb_vec_mem_sequencer;

  localparam int LANES  = 16;
  localparam int ELEM_W = 16;
  localparam int ADDR_W = 19;
  localparam int RD_W   = 5;
  localparam int VEC_W  = LANES * ELEM_W;

  logic clk;
  logic rst;
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W-1:0] req_stride;
  logic [RD_W-1:0]   req_rd;
  logic [VEC_W-1:0]  req_wdata;

  logic [1:0] ready_all, wren_all, done_all, rspv_all, stall_all, addr0_all, rsp0_all;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] b,
                                                 input logic [ADDR_W-1:0] s, input int i);
    logic [63:0] t;
    t = 64'(b) + 64'(s) * 64'(i);
    return t[ADDR_W-1:0];
  endfunction

  // RAM contents model: each word reads back as the low 16 address bits.
  function automatic logic [VEC_W-1:0] exp_vec(input logic [ADDR_W-1:0] b,
                                               input logic [ADDR_W-1:0] s);
    logic [VEC_W-1:0]  v;
    logic [ADDR_W-1:0] a;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      a = exp_addr(b, s, i);
      v[i*ELEM_W +: ELEM_W] = a[ELEM_W-1:0];
    end
    return v;
  endfunction

  // ---------------- DUT instances, RAM models, monitors ----------------
  for (genvar g = 0; g < 2; g++) begin : gen_inst
    localparam int LAT = (g == 0) ? 1 : 3;

    logic [ADDR_W-1:0] mem_addr;
    logic [ELEM_W-1:0] mem_wdata, mem_rdata;
    logic              mem_wren, req_ready, rsp_valid, done, stall;
    logic [RD_W-1:0]   rsp_rd;
    logic [VEC_W-1:0]  rsp_rdata;
    logic [1:0]        state_dbg;
    logic [ADDR_W-1:0] ram_pipe [LAT];

    bit                active = 1'b0;
    int                cyc = 0;
    int                end_c = 0;
    int                acc = 0;
    logic              m_wr;
    logic [ADDR_W-1:0] m_base, m_stride, ea;
    logic [RD_W-1:0]   m_rd;
    logic [VEC_W-1:0]  m_wdata;
    logic [VEC_W-1:0]  last_rsp = '0;
    logic [RD_W-1:0]   last_rd = '0;
    logic [VEC_W-1:0]  exp_q[$];

    vec_mem_sequencer #(
      .LANES(LANES), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .RD_W(RD_W), .MEM_LAT(LAT)
    ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_base(req_base), .req_stride(req_stride), .req_rd(req_rd), .req_wdata(req_wdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_rdata(rsp_rdata),
      .done(done), .stall(stall), .state_dbg(state_dbg)
    );

    // RAM with LAT cycles from address cycle to data valid.
    always @(posedge clk) begin
      ram_pipe[0] <= mem_addr;
      for (int j = 1; j < LAT; j++) ram_pipe[j] <= ram_pipe[j-1];
    end
    assign mem_rdata = ram_pipe[LAT-1][ELEM_W-1:0];

    assign ready_all[g] = req_ready;
    assign wren_all[g]  = mem_wren;
    assign done_all[g]  = done;
    assign rspv_all[g]  = rsp_valid;
    assign stall_all[g] = stall;
    assign addr0_all[g] = (mem_addr == '0);
    assign rsp0_all[g]  = (rsp_rdata == '0);

    // Cycle-by-cycle expectation; cycle 0 is the acceptance cycle.
    always @(negedge clk) begin
      if (!rst) begin
        active   = 1'b0;
        last_rsp = '0;
        last_rd  = '0;
        exp_q.delete();
      end else begin
        if (active) begin
          cyc++;
          end_c = m_wr ? LANES + 1 : LANES + LAT + 1;
          chk($sformatf("lat%0d c%0d stall", LAT, cyc), VEC_W'(stall), VEC_W'(1));
          chk($sformatf("lat%0d c%0d ready", LAT, cyc), VEC_W'(req_ready), VEC_W'(0));
          if (cyc <= LANES) begin
            ea = exp_addr(m_base, m_stride, cyc - 1);
            chk($sformatf("lat%0d c%0d addr", LAT, cyc), VEC_W'(mem_addr), VEC_W'(ea));
            chk($sformatf("lat%0d c%0d wren", LAT, cyc), VEC_W'(mem_wren), VEC_W'(m_wr));
            if (m_wr)
              chk($sformatf("lat%0d c%0d wdata", LAT, cyc), VEC_W'(mem_wdata),
                  VEC_W'(m_wdata[(cyc-1)*ELEM_W +: ELEM_W]));
          end else begin
            chk($sformatf("lat%0d c%0d wren", LAT, cyc), VEC_W'(mem_wren), VEC_W'(0));
          end
          chk($sformatf("lat%0d c%0d done", LAT, cyc), VEC_W'(done), VEC_W'(cyc == end_c));
          if (!m_wr && cyc == end_c && exp_q.size() > 0) begin
            last_rsp = exp_q.pop_front();
            last_rd  = m_rd;
            chk($sformatf("lat%0d c%0d rsp_valid", LAT, cyc), VEC_W'(rsp_valid), VEC_W'(1));
          end else begin
            chk($sformatf("lat%0d c%0d rsp_valid", LAT, cyc), VEC_W'(rsp_valid), VEC_W'(0));
          end
          if (cyc == end_c) active = 1'b0;
        end else begin
          chk($sformatf("lat%0d idle ready", LAT), VEC_W'(req_ready), VEC_W'(1));
          chk($sformatf("lat%0d idle stall", LAT), VEC_W'(stall), VEC_W'(0));
          chk($sformatf("lat%0d idle wren", LAT), VEC_W'(mem_wren), VEC_W'(0));
          chk($sformatf("lat%0d idle done", LAT), VEC_W'(done), VEC_W'(0));
          chk($sformatf("lat%0d idle rsp_valid", LAT), VEC_W'(rsp_valid), VEC_W'(0));
          if (req_valid) begin
            active   = 1'b1;
            cyc      = 0;
            acc++;
            m_wr     = req_write;
            m_base   = req_base;
            m_stride = req_stride;
            m_rd     = req_rd;
            m_wdata  = req_wdata;
            if (!req_write) exp_q.push_back(exp_vec(req_base, req_stride));
          end
        end
        chk($sformatf("lat%0d rsp_rdata", LAT), rsp_rdata, last_rsp);
        chk($sformatf("lat%0d rsp_rd", LAT), VEC_W'(rsp_rd), VEC_W'(last_rd));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    for (int t = 0; t < 200; t++) begin
      if (ready_all == 2'b11) break;
      @(posedge clk);
      #1;
    end
    chk("idle wait", VEC_W'(ready_all), VEC_W'(2'b11));
  endtask

  task automatic drive(input logic wr, input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                       input logic [RD_W-1:0] rd, input logic [VEC_W-1:0] wd);
    req_write  = wr;
    req_base   = b;
    req_stride = s;
    req_rd     = rd;
    req_wdata  = wd;
    req_valid  = 1'b1;
  endtask

  task automatic send(input logic wr, input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                      input logic [RD_W-1:0] rd, input logic [VEC_W-1:0] wd);
    wait_idle();
    drive(wr, b, s, rd, wd);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_idle();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, " wren"}, VEC_W'(wren_all), VEC_W'(0));
    chk({tag, " done"}, VEC_W'(done_all), VEC_W'(0));
    chk({tag, " rsp_valid"}, VEC_W'(rspv_all), VEC_W'(0));
    chk({tag, " ready"}, VEC_W'(ready_all), VEC_W'(2'b11));
    chk({tag, " stall"}, VEC_W'(stall_all), VEC_W'(0));
    chk({tag, " addr zero"}, VEC_W'(addr0_all), VEC_W'(2'b11));
    chk({tag, " rsp_rdata zero"}, VEC_W'(rsp0_all), VEC_W'(2'b11));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [VEC_W-1:0] wd;
    int a0, a1;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_base   = '0;
    req_stride = '0;
    req_rd     = '0;
    req_wdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Unit-stride load (timing checked at both read latencies).
    send(1'b0, 19'h00010, 19'd1, 5'd3, '0);

    // Stride-2 store, lane i = 0xA000+i.
    for (int i = 0; i < LANES; i++) wd[i*ELEM_W +: ELEM_W] = 16'hA000 + 16'(i);
    send(1'b1, 19'h00100, 19'd2, 5'd7, wd);

    // Address wrap, then stride-0 broadcast.
    send(1'b0, 19'h7FFFE, 19'd1, 5'd9, '0);
    send(1'b0, 19'h00005, 19'd0, 5'd11, '0);

    // req_valid held across two requests.
    wait_idle();
    a0 = gen_inst[0].acc;
    a1 = gen_inst[1].acc;
    drive(1'b0, 19'h00200, 19'd3, 5'd1, '0);
    @(posedge clk);
    #1;
    for (int i = 0; i < LANES; i++) wd[i*ELEM_W +: ELEM_W] = 16'($urandom);
    drive(1'b1, 19'h00040, 19'd5, 5'd2, wd);
    for (int t = 0; t < 100; t++) begin
      if (gen_inst[0].acc >= a0 + 2 && gen_inst[1].acc >= a1 + 2) break;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("held accept lat1", VEC_W'(gen_inst[0].acc), VEC_W'(a0 + 2));
    chk("held accept lat3", VEC_W'(gen_inst[1].acc), VEC_W'(a1 + 2));
    wait_idle();

    // Reset mid-load at lane 7.
    drive(1'b0, 19'h00300, 19'd1, 5'd4, '0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    reset_checks("midload");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset mid-store at lane 3.
    drive(1'b1, 19'h00400, 19'd1, 5'd6, wd);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midstore wren before", VEC_W'(wren_all), VEC_W'(2'b11));
    rst = 1'b0;
    #1;
    reset_checks("midstore");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Clean load after the aborted operations.
    send(1'b0, 19'h01234, 19'd7, 5'd13, '0);

    // Randomised traffic.
    for (int n = 0; n < 16; n++) begin
      logic [ADDR_W-1:0] s;
      case ($urandom_range(0, 3))
        0:       s = '0;
        1:       s = 19'd1;
        2:       s = 19'($urandom_range(2, 64));
        default: s = 19'($urandom);
      endcase
      for (int i = 0; i < LANES; i++) wd[i*ELEM_W +: ELEM_W] = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(1'($urandom_range(0, 1)), 19'($urandom), s, 5'($urandom), wd);
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
